// File: rtl/wifi_interleaver_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wifi_intlv_pkg
// Shared definitions for the 802.11a interleaver FIFO sequencer:
//   - FSM state encoding (IDLE / FILL / DRAIN)
//   - per-modulation N_BPSC / N_CBPS lookup constants and helpers
//   - N_CBPS_MAX, the largest symbol size the FIFO must hold
// No ports; imported by wifi_interleaver_ctrl and wifi_intlv_addr_gen.
// ---------------------------------------------------------------------------
package wifi_intlv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int N_BPSC_BPSK  = 1;
  localparam int N_BPSC_QPSK  = 2;
  localparam int N_BPSC_16QAM = 4;
  localparam int N_BPSC_64QAM = 6;

  localparam int N_CBPS_MAX   = 288;
  localparam int N_CBPS_BPSK  = 48;
  localparam int N_CBPS_QPSK  = 96;
  localparam int N_CBPS_16QAM = 192;
  localparam int N_CBPS_64QAM = N_CBPS_MAX;

  // Coded bits per subcarrier.
  function automatic logic [2:0] n_bpsc(input logic [1:0] m);
    case (m)
      2'b00:   return 3'(N_BPSC_BPSK);
      2'b01:   return 3'(N_BPSC_QPSK);
      2'b10:   return 3'(N_BPSC_16QAM);
      default: return 3'(N_BPSC_64QAM);
    endcase
  endfunction

  // Coded bits per OFDM symbol.
  function automatic logic [8:0] n_cbps(input logic [1:0] m);
    case (m)
      2'b00:   return 9'(N_CBPS_BPSK);
      2'b01:   return 9'(N_CBPS_QPSK);
      2'b10:   return 9'(N_CBPS_16QAM);
      default: return 9'(N_CBPS_64QAM);
    endcase
  endfunction

  // Number of columns of the 16-row interleaver matrix (N_CBPS/16).
  function automatic logic [4:0] n_col(input logic [1:0] m);
    logic [8:0] n;
    n = n_cbps(m) >> 4;
    return n[4:0];
  endfunction

  // s = max(N_BPSC/2, 1)
  function automatic logic [1:0] s_of(input logic [1:0] m);
    logic [2:0] h;
    h = n_bpsc(m) >> 1;
    return (h == 3'd0) ? 2'd1 : h[1:0];
  endfunction

  // Reduce v modulo s, valid for 0 <= v < 2*s.
  function automatic logic [1:0] mod_wrap(input logic [2:0] v, input logic [1:0] s);
    logic [2:0] r;
    r = (v >= {1'b0, s}) ? (v - {1'b0, s}) : v;
    return r[1:0];
  endfunction

endpackage

// File: rtl/wifi_interleaver_ctrl_if.sv
// ---------------------------------------------------------------------------
// wifi_interleaver_ctrl_if
// Handshake / FIFO-control bundle of the interleaver sequencer.
//   mod[1:0]            modulation, sampled at block start
//   dir                 (WIFI_INTLV_DEINT_EN only) 1 = RX deinterleave
//   in_valid / in_ready coded-bit input handshake
//   fifo_we             FIFO write enable
//   fifo_re             FIFO read enable
//   fifo_reset_enable   clears the FIFO write pointer
//   fifo_read_address   permuted FIFO read address
//   out_valid/out_ready interleaved-bit output handshake
//   block_done          pulse on acceptance of the last bit of a block
// Modports: slave = controller side, master = environment side.
// ---------------------------------------------------------------------------
interface wifi_interleaver_ctrl_if #(
  parameter int AD = 9
);
  logic [1:0]    mod;
`ifdef WIFI_INTLV_DEINT_EN
  logic          dir;
`endif
  logic          in_valid;
  logic          in_ready;
  logic          fifo_we;
  logic          fifo_re;
  logic          fifo_reset_enable;
  logic [AD-1:0] fifo_read_address;
  logic          out_valid;
  logic          out_ready;
  logic          block_done;

  modport slave (
    input  mod,
`ifdef WIFI_INTLV_DEINT_EN
    input  dir,
`endif
    input  in_valid,
    input  out_ready,
    output in_ready,
    output fifo_we,
    output fifo_re,
    output fifo_reset_enable,
    output fifo_read_address,
    output out_valid,
    output block_done
  );

  modport master (
    output mod,
`ifdef WIFI_INTLV_DEINT_EN
    output dir,
`endif
    output in_valid,
    output out_ready,
    input  in_ready,
    input  fifo_we,
    input  fifo_re,
    input  fifo_reset_enable,
    input  fifo_read_address,
    input  out_valid,
    input  block_done
  );
endinterface

// File: rtl/wifi_interleaver_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// wifi_intlv_addr_gen
// Produces the FIFO read address for output index j without dividers.
// Ports:
//   clk, reset (async, active-low)
//   start     zero all counters (block start)
//   advance   step to the next output index j
//   lat_mod   latched modulation of the current block
//   dir       (WIFI_INTLV_DEINT_EN only) 1 = forward permutation (RX)
//   fifo_read_address  address for the current j (combinational from counters)
// Macro WIFI_INTLV_DEINT_EN adds the RX permutation.
//
// TX: j is walked as (row r, column c) with j = r*N/16 + c. Because N/16 is a
// multiple of s, an s-aligned group never crosses a row, so floor(16*i/N) = r
// and the read address collapses to 16*(c - c%s + (c%s + r%s)%s) + r.
// RX: j is walked as (m = j%16, q = j/16); k' = (N/16)*m + q, floor(16k'/N) = m
// and N%s = 0, so addr = k' - q%s + (q%s - m%s) mod s.
// ---------------------------------------------------------------------------
module wifi_intlv_addr_gen
  import wifi_intlv_pkg::*;
#(
  parameter int AD = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          advance,
  input  logic [1:0]    lat_mod,
`ifdef WIFI_INTLV_DEINT_EN
  input  logic          dir,
`endif
  output logic [AD-1:0] fifo_read_address
);

  logic [4:0] ncol;
  logic [1:0] s;

  // inner = fastest-moving index (TX: column c, RX: m); outer = slower one
  logic [4:0] inner_q, outer_q;
  logic [1:0] inner_m_q, outer_m_q;   // inner/outer modulo s
  logic       inner_last;

  logic [1:0]    tx_sum;
  logic [4:0]    tx_col;
  logic [AD-1:0] addr_tx;

  assign ncol = n_col(lat_mod);
  assign s    = s_of(lat_mod);

`ifdef WIFI_INTLV_DEINT_EN
  logic [AD-1:0] base_q;              // (N/16)*m, accumulated in RX
  logic [1:0]    rx_off;
  logic [AD-1:0] addr_rx;

  assign inner_last = dir ? (inner_q == 5'd15) : (inner_q == ncol - 5'd1);
`else
  assign inner_last = (inner_q == ncol - 5'd1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inner_q   <= '0;
      outer_q   <= '0;
      inner_m_q <= '0;
      outer_m_q <= '0;
`ifdef WIFI_INTLV_DEINT_EN
      base_q    <= '0;
`endif
    end else if (start) begin
      inner_q   <= '0;
      outer_q   <= '0;
      inner_m_q <= '0;
      outer_m_q <= '0;
`ifdef WIFI_INTLV_DEINT_EN
      base_q    <= '0;
`endif
    end else if (advance) begin
      if (inner_last) begin
        // inner wraps to 0, so its residue restarts at 0 even when 16 % s != 0
        inner_q   <= '0;
        inner_m_q <= '0;
        outer_q   <= outer_q + 5'd1;
        outer_m_q <= mod_wrap({1'b0, outer_m_q} + 3'd1, s);
`ifdef WIFI_INTLV_DEINT_EN
        base_q    <= '0;
`endif
      end else begin
        inner_q   <= inner_q + 5'd1;
        inner_m_q <= mod_wrap({1'b0, inner_m_q} + 3'd1, s);
`ifdef WIFI_INTLV_DEINT_EN
        base_q    <= base_q + AD'(ncol);
`endif
      end
    end
  end

  // TX: column index after the intra-group rotation, then 16*col + row
  assign tx_sum  = mod_wrap({1'b0, inner_m_q} + {1'b0, outer_m_q}, s);
  assign tx_col  = inner_q - {3'b000, inner_m_q} + {3'b000, tx_sum};
  assign addr_tx = AD'({tx_col, 4'b0000}) + AD'(outer_q);

`ifdef WIFI_INTLV_DEINT_EN
  // (q%s + s - m%s) stays within [1, 2s-1], so one conditional subtract suffices
  assign rx_off  = mod_wrap({1'b0, outer_m_q} + {1'b0, s} - {1'b0, inner_m_q}, s);
  assign addr_rx = base_q + AD'(outer_q) - AD'(outer_m_q) + AD'(rx_off);
  assign fifo_read_address = dir ? addr_rx : addr_tx;
`else
  assign fifo_read_address = addr_tx;
`endif

endmodule

// File: rtl/wifi_interleaver_ctrl.sv
// ---------------------------------------------------------------------------
// wifi_interleaver_ctrl
// Sequencer for the 1-bit interleaver FIFO: fills one OFDM symbol of N_CBPS
// coded bits in arrival order, then drains it in 802.11a interleaved order by
// driving the FIFO read address. The bit itself bypasses this block.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    wifi_interleaver_ctrl_if.slave (mod, [dir], in_valid/in_ready,
//          fifo_we, fifo_re, fifo_reset_enable, fifo_read_address,
//          out_valid/out_ready, block_done)
// Parameter AD: FIFO address width, 2**AD >= 288.
// Macro WIFI_INTLV_DEINT_EN: adds dir (RX deinterleave).
// ---------------------------------------------------------------------------
module wifi_interleaver_ctrl
  import wifi_intlv_pkg::*;
#(
  parameter int AD = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  wifi_interleaver_ctrl_if.slave bus
);

  state_t        state_q, state_d;
  logic [1:0]    lat_mod_q;
`ifdef WIFI_INTLV_DEINT_EN
  logic          lat_dir_q;
`endif
  logic [AD-1:0] wr_cnt_q, rd_cnt_q, acc_cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [AD-1:0] lat_n, last_idx;
  logic          accept_in, accept_out, start_blk;
  logic          fifo_re, last_out;

  assign lat_n      = AD'(n_cbps(lat_mod_q));
  assign last_idx   = lat_n - AD'(1);
  assign accept_in  = bus.in_valid & in_ready_q;
  assign accept_out = out_valid_q & bus.out_ready;
  assign start_blk  = (state_q == IDLE) & accept_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_re  = 1'b0;
    last_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_in) state_d = FILL;
      end
      FILL: begin
        if (accept_in && (wr_cnt_q == last_idx)) state_d = DRAIN;
      end
      DRAIN: begin
        // read only when the output register is empty or being emptied
        fifo_re  = (rd_cnt_q < lat_n) && (!out_valid_q || bus.out_ready);
        last_out = accept_out && (acc_cnt_q == last_idx);
        if (last_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_mod_q   <= 2'b00;
`ifdef WIFI_INTLV_DEINT_EN
      lat_dir_q   <= 1'b0;
`endif
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // registered so that in_ready is 0 while reset is held and for the
      // first cycle after; it then follows "not draining"
      in_ready_q <= (state_d != DRAIN);

      if (start_blk) begin
        lat_mod_q <= bus.mod;
`ifdef WIFI_INTLV_DEINT_EN
        lat_dir_q <= bus.dir;
`endif
        wr_cnt_q  <= AD'(1);
        rd_cnt_q  <= '0;
        acc_cnt_q <= '0;
      end else if ((state_q == FILL) && accept_in) begin
        wr_cnt_q <= wr_cnt_q + AD'(1);
      end

      if (fifo_re)    rd_cnt_q  <= rd_cnt_q + AD'(1);
      if ((state_q == DRAIN) && accept_out) acc_cnt_q <= acc_cnt_q + AD'(1);

      if (last_out) begin
        wr_cnt_q  <= '0;
        rd_cnt_q  <= '0;
        acc_cnt_q <= '0;
      end

      if (fifo_re)            out_valid_q <= 1'b1;
      else if (bus.out_ready) out_valid_q <= 1'b0;
    end
  end

  wifi_intlv_addr_gen #(
    .AD(AD)
  ) u_addr_gen (
    .clk               (clk),
    .reset             (reset),
    .start             (start_blk),
    .advance           (fifo_re),
    .lat_mod           (lat_mod_q),
`ifdef WIFI_INTLV_DEINT_EN
    .dir               (lat_dir_q),
`endif
    .fifo_read_address (bus.fifo_read_address)
  );

  assign bus.in_ready          = in_ready_q;
  assign bus.fifo_we           = accept_in;
  assign bus.fifo_re           = fifo_re;
  assign bus.out_valid         = out_valid_q;
  assign bus.block_done        = last_out;
  assign bus.fifo_reset_enable = last_out;

endmodule

// File: tb/tb_wifi_interleaver_ctrl.sv
module tb_wifi_interleaver_ctrl;

  localparam int AD = 9;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic in_bit;
  logic rand_ready;

  always #5 clk = ~clk;

  wifi_interleaver_ctrl_if #(.AD(AD)) bus ();

  wifi_interleaver_ctrl #(.AD(AD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 1-bit FIFO with 1-cycle read latency
  logic          fifo_mem [512];
  logic [AD-1:0] wp;
  logic          dout;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp   <= '0;
      dout <= 1'b0;
    end else begin
      if (bus.fifo_we) begin
        fifo_mem[wp] <= in_bit;
        wp           <= wp + 1'b1;
      end
      if (bus.fifo_reset_enable) wp <= '0;
      if (bus.fifo_re) dout <= fifo_mem[bus.fifo_read_address];
    end
  end

  // scoreboard
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_addr_q [$];
  int   exp_bit_q  [$];
  int   exp_len_q  [$];
  int   acc_blk  = 0;
  int   wr_blk   = 0;
  int   done_cnt = 0;
  int   cap_len  = 0;
  logic cap [288];
  logic blk [288];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference permutations written straight from the 802.11a definitions
  function automatic int tb_n(input logic [1:0] m);
    case (m)
      2'b00: return 48;
      2'b01: return 96;
      2'b10: return 192;
      default: return 288;
    endcase
  endfunction

  function automatic int tb_s(input logic [1:0] m);
    case (m)
      2'b10: return 2;
      2'b11: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int tx_addr(input int j, input int n, input int s);
    int i;
    i = s * (j / s) + ((j + (16 * j) / n) % s);
    return 16 * i - (n - 1) * ((16 * i) / n);
  endfunction

  function automatic int rx_addr(input int j, input int n, input int s);
    int kp;
    kp = (n / 16) * (j % 16) + j / 16;
    return s * (kp / s) + ((kp + n - (16 * kp) / n) % s);
  endfunction

  function automatic int find_one();
    for (int j = 0; j < cap_len; j++) if (cap[j] === 1'b1) return j;
    return -1;
  endfunction

  // monitor: pops and compares whenever the DUT presents something
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        acc_blk = 0;
        wr_blk  = 0;
      end else begin
        if (bus.fifo_we) wr_blk++;
        if (bus.fifo_re) begin
          if (exp_addr_q.size() == 0) check("addr_underflow", 1, 0);
          else check("read_addr", int'(bus.fifo_read_address), exp_addr_q.pop_front());
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_bit_q.size() == 0) check("bit_underflow", 1, 0);
          else check("out_bit", int'(dout), exp_bit_q.pop_front());
          if (acc_blk < 288) cap[acc_blk] = dout;
          acc_blk++;
        end
        if (bus.block_done) begin
          if (exp_len_q.size() == 0) check("done_underflow", 1, 0);
          else begin
            int n;
            n = exp_len_q.pop_front();
            check("blk_accepted", acc_blk, n);
            check("blk_written", wr_blk, n);
            check("fifo_reset_en", int'(bus.fifo_reset_enable), 1);
          end
          $display("block %0d done: %0d bits out, %0d bits in", done_cnt, acc_blk, wr_blk);
          cap_len = acc_blk;
          acc_blk = 0;
          wr_blk  = 0;
          done_cnt++;
        end
      end
    end
  end

  // downstream ready: always 1, or a pseudo-random 50% pattern
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    in_bit       = b;
    @(negedge clk);
    while (!bus.in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // push expectations for a full block, then feed n_bits of blk[]
  task automatic send_block(input logic [1:0] m, input logic d, input int n_bits,
                            input bit push, input logic [1:0] m_after);
    int n, s, a;
    n = tb_n(m);
    s = tb_s(m);
    if (push) begin
      for (int j = 0; j < n; j++) begin
        a = d ? rx_addr(j, n, s) : tx_addr(j, n, s);
        exp_addr_q.push_back(a);
        exp_bit_q.push_back(int'(blk[a]));
      end
      exp_len_q.push_back(n);
    end
    bus.mod = m;
`ifdef WIFI_INTLV_DEINT_EN
    bus.dir = d;
`endif
    for (int k = 0; k < n_bits; k++) begin
      send_bit(blk[k]);
      if (k == 0) bus.mod = m_after;
    end
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while ((exp_len_q.size() != 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check(name, 0, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic int outs_word();
    return int'({bus.in_ready, bus.fifo_we, bus.fifo_re, bus.fifo_reset_enable,
                 bus.out_valid, bus.block_done, bus.fifo_read_address});
  endfunction

  logic ref_cap [288];
  logic tx1     [48];

  initial begin
    int diff, d0;
    bus.mod      = 2'b00;
    bus.in_valid = 1'b0;
    in_bit       = 1'b0;
    rand_ready   = 1'b0;
`ifdef WIFI_INTLV_DEINT_EN
    bus.dir      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs_word(), 0);
    reset = 1'b1;

    // 1: BPSK, only k=1 set
    for (int k = 0; k < 288; k++) blk[k] = 1'b0;
    blk[1] = 1'b1;
    send_block(2'b00, 1'b0, 48, 1'b1, 2'b00);
    wait_idle("t1_timeout");
    check("t1_one_at_j", find_one(), 3);
    for (int j = 0; j < 48; j++) tx1[j] = cap[j];

    // 2: 16QAM, only k=1 set
    send_block(2'b10, 1'b0, 192, 1'b1, 2'b10);
    wait_idle("t2_timeout");
    check("t2_one_at_j", find_one(), 13);

    // 3: 64QAM, ready=1 reference run then random back-pressure
    for (int k = 0; k < 288; k++) blk[k] = ((k % 7) == 0) ^ ((k % 5) == 1);
    send_block(2'b11, 1'b0, 288, 1'b1, 2'b11);
    wait_idle("t3a_timeout");
    for (int j = 0; j < 288; j++) ref_cap[j] = cap[j];
    rand_ready = 1'b1;
    send_block(2'b11, 1'b0, 288, 1'b1, 2'b11);
    wait_idle("t3b_timeout");
    rand_ready = 1'b0;
    check("t3_len", cap_len, 288);
    diff = 0;
    for (int j = 0; j < 288; j++) if (cap[j] !== ref_cap[j]) diff++;
    check("t3_seq_diff", diff, 0);

    // 4: QPSK with mod forced to 11 mid-block, then a 64QAM block
    d0 = done_cnt;
    for (int k = 0; k < 288; k++) blk[k] = ((k % 3) == 0);
    send_block(2'b01, 1'b0, 96, 1'b1, 2'b11);
    for (int k = 0; k < 288; k++) blk[k] = ((k % 4) == 1);
    send_block(2'b11, 1'b0, 288, 1'b1, 2'b11);
    wait_idle("t4_timeout");
    check("t4_blocks", done_cnt - d0, 2);

    // 5: reset while filling at k=20
    for (int k = 0; k < 288; k++) blk[k] = ((k % 2) == 0);
    send_block(2'b00, 1'b0, 20, 1'b0, 2'b00);
    bus.in_valid = 1'b1;
    in_bit       = 1'b1;
    reset        = 1'b0;
    #1;
    check("t5_outputs_async", outs_word(), 0);
    @(negedge clk);
    check("t5_outputs_edge", outs_word(), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 288; k++) blk[k] = ((k % 5) == 2);
    send_block(2'b01, 1'b0, 96, 1'b1, 2'b01);
    wait_idle("t5_timeout");
    check("t5_blocks", done_cnt - d0, 1);

`ifdef WIFI_INTLV_DEINT_EN
    // 6: deinterleave the interleaved output of test 1
    for (int k = 0; k < 288; k++) blk[k] = 1'b0;
    for (int k = 0; k < 48; k++) blk[k] = tx1[k];
    send_block(2'b00, 1'b1, 48, 1'b1, 2'b00);
    wait_idle("t6_timeout");
    check("t6_one_at_j", find_one(), 1);
`endif

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
